// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// Module   : reg_wb_arbiter
// Purpose  : Register-file write-port arbiter (ex vs load return) with a
//            load-outstanding scoreboard. Optional bypass: WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_wb_arbiter #(
    parameter int MAX_STALL  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    output logic                       ex_ready,
    input  logic [ADDR_WIDTH-1:0]      ex_addr,
    input  logic [DATA_WIDTH-1:0]      ex_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_data,
    input  logic                       mark_valid,
    input  logic [ADDR_WIDTH-1:0]      mark_addr,
    input  logic [ADDR_WIDTH-1:0]      raddr1,
    input  logic [ADDR_WIDTH-1:0]      raddr2,
    output logic                       stall1,
    output logic                       stall2,
`ifdef WB_BYPASS_EN
    output logic                       byp1_en,
    output logic                       byp2_en,
    output logic [DATA_WIDTH-1:0]      byp_data,
`endif
    output logic                       wen,
    output logic [ADDR_WIDTH-1:0]      waddr,
    output logic [DATA_WIDTH-1:0]      wdata,
    output logic [(2**ADDR_WIDTH)-1:0] busy
);

    localparam int         c_depth     = 2**ADDR_WIDTH;
    localparam logic [2:0] c_max_stall = 3'(MAX_STALL);
    localparam logic       c_src_ex    = 1'b0;
    localparam logic       c_src_mem   = 1'b1;

    logic [2:0]            r_loss_cnt;
    logic [2:0]            w_loss_nxt;
    logic                  r_wr_src;
    logic [c_depth-1:0]    r_busy;
    logic [c_depth-1:0]    w_busy_nxt;
    logic                  w_ex_win;
    logic                  w_mem_win;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_data;

    // mem has priority until ex has lost MAX_STALL consecutive contests
    always_comb begin
        w_ex_win   = ex_valid & (~mem_valid | (r_loss_cnt >= c_max_stall));
        w_mem_win  = mem_valid & ~w_ex_win;
        w_accept   = w_ex_win | w_mem_win;
        w_acc_addr = w_ex_win ? ex_addr : mem_addr;
        w_acc_data = w_ex_win ? ex_data : mem_data;
    end

    assign ex_ready  = w_ex_win;
    assign mem_ready = w_mem_win;

    always_comb begin
        w_loss_nxt = 3'd0;
        if (ex_valid && w_mem_win) begin
            w_loss_nxt = (r_loss_cnt >= c_max_stall) ? c_max_stall : r_loss_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loss_cnt <= 3'd0;
        end else begin
            r_loss_cnt <= w_loss_nxt;
        end
    end

    // Writes to r0 complete the handshake but never raise wen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen      <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            r_wr_src <= c_src_ex;
        end else if (w_accept) begin
            wen      <= (w_acc_addr != '0);
            waddr    <= w_acc_addr;
            wdata    <= w_acc_data;
            r_wr_src <= w_ex_win ? c_src_ex : c_src_mem;
        end else begin
            wen      <= 1'b0;
        end
    end

    // Clear applied before set so a new load to the same register wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (wen && (r_wr_src == c_src_mem)) begin
            w_busy_nxt[waddr] = 1'b0;
        end
        if (mark_valid && (mark_addr != '0)) begin
            w_busy_nxt[mark_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

`ifdef WB_BYPASS_EN
    assign byp1_en  = wen & (waddr == raddr1) & (raddr1 != '0);
    assign byp2_en  = wen & (waddr == raddr2) & (raddr2 != '0);
    assign byp_data = wdata;
    assign stall1   = r_busy[raddr1] & (raddr1 != '0) & ~byp1_en;
    assign stall2   = r_busy[raddr2] & (raddr2 != '0) & ~byp2_en;
`else
    assign stall1   = r_busy[raddr1] & (raddr1 != '0);
    assign stall2   = r_busy[raddr2] & (raddr2 != '0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
// ============================================================================
// Module   : tb_reg_wb_arbiter
// Purpose  : Directed self-checking bench for reg_wb_arbiter (MAX_STALL=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mark_valid;
    logic [4:0]  mark_addr;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        stall1;
    logic        stall2;
`ifdef WB_BYPASS_EN
    logic        byp1_en;
    logic        byp2_en;
    logic [31:0] byp_data;
`endif
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] busy;

    int tests;
    int fails;

    reg_wb_arbiter #(
        .MAX_STALL  (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_addr    (ex_addr),
        .ex_data    (ex_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mark_valid (mark_valid),
        .mark_addr  (mark_addr),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .stall1     (stall1),
        .stall2     (stall2),
`ifdef WB_BYPASS_EN
        .byp1_en    (byp1_en),
        .byp2_en    (byp2_en),
        .byp_data   (byp_data),
`endif
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        ex_addr    = '0;
        ex_data    = '0;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        mark_valid = 1'b0;
        mark_addr  = '0;
        raddr1     = '0;
        raddr2     = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        tests++;
        if (wen !== 1'b0) begin
            fails++; $display("FAIL reset_wen: got %b expected 0", wen);
        end
        tests++;
        if (waddr !== 5'd0 || wdata !== 32'd0) begin
            fails++; $display("FAIL reset_wdata: got addr %0d data %h expected 0/0", waddr, wdata);
        end
        tests++;
        if (busy !== 32'd0) begin
            fails++; $display("FAIL reset_busy: got %h expected 0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_ex();
        ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 32'h12345678;
        #1;
        tests++;
        if (ex_ready !== 1'b1 || mem_ready !== 1'b0) begin
            fails++; $display("FAIL single_ready: got ex %b mem %b expected 1/0", ex_ready, mem_ready);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        tests++;
        if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h12345678) begin
            fails++; $display("FAIL single_write: got %b/%0d/%h expected 1/5/12345678", wen, waddr, wdata);
        end
        @(negedge clk);
        tests++;
        if (wen !== 1'b0 || waddr !== 5'd5 || wdata !== 32'h12345678) begin
            fails++; $display("FAIL single_hold: got %b/%0d/%h expected 0/5/12345678", wen, waddr, wdata);
        end
    endtask

    task automatic test_contention();
        ex_valid  = 1'b1; ex_addr  = 5'd1; ex_data  = 32'h111;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h222;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++;
            if (ex_ready !== (c == 4) || mem_ready !== (c != 4)) begin
                fails++; $display("FAIL contention_grant cycle %0d: got ex %b mem %b expected %b/%b",
                                  c, ex_ready, mem_ready, (c == 4), (c != 4));
            end
            @(negedge clk);
            tests++;
            if (wen !== 1'b1 || waddr !== ((c == 4) ? 5'd1 : 5'd2)) begin
                fails++; $display("FAIL contention_write cycle %0d: got %b/%0d expected 1/%0d",
                                  c, wen, waddr, (c == 4) ? 1 : 2);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_loss_clear();
        logic [8:0] exv;
        logic [8:0] exp_ex;
        exv    = 9'b111110111;
        exp_ex = 9'b100000000;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h333;
        ex_addr   = 5'd1; ex_data  = 32'h444;
        for (int c = 0; c < 9; c++) begin
            ex_valid = exv[c];
            #1;
            tests++;
            if (ex_ready !== exp_ex[c] || mem_ready !== ~exp_ex[c]) begin
                fails++; $display("FAIL loss_clear cycle %0d: got ex %b mem %b expected %b/%b",
                                  c, ex_ready, mem_ready, exp_ex[c], ~exp_ex[c]);
            end
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_scoreboard();
        mark_valid = 1'b1; mark_addr = 5'd7; raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        tests++;
        if (stall1 !== 1'b0) begin
            fails++; $display("FAIL sb_pre_mark: got stall1 %b expected 0", stall1);
        end
        @(negedge clk);
        mark_valid = 1'b0;
        tests++;
        if (stall1 !== 1'b1 || stall2 !== 1'b1 || busy[7] !== 1'b1) begin
            fails++; $display("FAIL sb_marked: got %b/%b busy7 %b expected 1/1/1", stall1, stall2, busy[7]);
        end
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hCAFE0007;
        #1;
        tests++;
        if (mem_ready !== 1'b1 || stall1 !== 1'b1) begin
            fails++; $display("FAIL sb_accept: got ready %b stall1 %b expected 1/1", mem_ready, stall1);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        tests++;
        if (wen !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hCAFE0007) begin
            fails++; $display("FAIL sb_commit: got %b/%0d/%h expected 1/7/cafe0007", wen, waddr, wdata);
        end
`ifdef WB_BYPASS_EN
        tests++;
        if (stall1 !== 1'b0 || byp1_en !== 1'b1 || byp_data !== 32'hCAFE0007) begin
            fails++; $display("FAIL sb_bypass: got stall1 %b byp1 %b data %h expected 0/1/cafe0007",
                              stall1, byp1_en, byp_data);
        end
`else
        tests++;
        if (stall1 !== 1'b1 || busy[7] !== 1'b1) begin
            fails++; $display("FAIL sb_inflight: got stall1 %b busy7 %b expected 1/1", stall1, busy[7]);
        end
`endif
        @(negedge clk);
        tests++;
        if (stall1 !== 1'b0 || stall2 !== 1'b0 || busy[7] !== 1'b0) begin
            fails++; $display("FAIL sb_cleared: got %b/%b busy7 %b expected 0/0/0", stall1, stall2, busy[7]);
        end
        idle_inputs();
    endtask

    task automatic test_ex_no_clear();
        mark_valid = 1'b1; mark_addr = 5'd4; raddr1 = 5'd4;
        @(negedge clk);
        mark_valid = 1'b0;
        ex_valid = 1'b1; ex_addr = 5'd4; ex_data = 32'h44;
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy[4] !== 1'b1 || stall1 !== 1'b1) begin
            fails++; $display("FAIL ex_no_clear: got busy4 %b stall1 %b expected 1/1", busy[4], stall1);
        end
        mem_valid = 1'b1; mem_addr = 5'd4;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 32'd0) begin
            fails++; $display("FAIL mem_clear4: got %h expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        mark_valid = 1'b1; mark_addr = 5'd9; raddr1 = 5'd9;
        @(negedge clk);
        mark_valid = 1'b0;
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h99;
        @(negedge clk);
        mem_valid = 1'b0;
        mark_valid = 1'b1; mark_addr = 5'd9;
        tests++;
        if (wen !== 1'b1 || waddr !== 5'd9) begin
            fails++; $display("FAIL collide_commit: got %b/%0d expected 1/9", wen, waddr);
        end
        @(negedge clk);
        mark_valid = 1'b0;
        tests++;
        if (busy[9] !== 1'b1 || stall1 !== 1'b1) begin
            fails++; $display("FAIL collide_set_wins: got busy9 %b stall1 %b expected 1/1", busy[9], stall1);
        end
        mem_valid = 1'b1; mem_addr = 5'd9;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy[9] !== 1'b0) begin
            fails++; $display("FAIL collide_cleanup: got busy9 %b expected 0", busy[9]);
        end
        idle_inputs();
    endtask

    task automatic test_addr0();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEAD0000;
        mark_valid = 1'b1; mark_addr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        tests++;
        if (mem_ready !== 1'b1) begin
            fails++; $display("FAIL addr0_ready: got %b expected 1", mem_ready);
        end
        @(negedge clk);
        idle_inputs();
        tests++;
        if (wen !== 1'b0 || busy !== 32'd0) begin
            fails++; $display("FAIL addr0_discard: got wen %b busy %h expected 0/0", wen, busy);
        end
        tests++;
        if (stall1 !== 1'b0 || stall2 !== 1'b0) begin
            fails++; $display("FAIL addr0_stall: got %b/%b expected 0/0", stall1, stall2);
        end
        ex_valid = 1'b1; ex_addr = 5'd0; ex_data = 32'h1;
        @(negedge clk);
        ex_valid = 1'b0;
        tests++;
        if (wen !== 1'b0) begin
            fails++; $display("FAIL addr0_ex_discard: got wen %b expected 0", wen);
        end
    endtask

    task automatic test_reset_mid_write();
        mark_valid = 1'b1; mark_addr = 5'd6;
        @(negedge clk);
        mark_valid = 1'b0;
        ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 32'hA5A5A5A5;
        @(negedge clk);
        ex_valid = 1'b0;
        tests++;
        if (wen !== 1'b1 || waddr !== 5'd3 || busy[6] !== 1'b1) begin
            fails++; $display("FAIL rmw_setup: got %b/%0d busy6 %b expected 1/3/1", wen, waddr, busy[6]);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (wen !== 1'b0 || busy !== 32'd0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            fails++; $display("FAIL rmw_async: got wen %b busy %h addr %0d data %h expected 0/0/0/0",
                              wen, busy, waddr, wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (wen !== 1'b0 || waddr !== 5'd0) begin
            fails++; $display("FAIL rmw_no_write: got %b/%0d expected 0/0", wen, waddr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_ex();
        test_contention();
        test_loss_clear();
        test_scoreboard();
        test_ex_no_clear();
        test_collision();
        test_addr0();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
